xy_response_checker: RTL and testbench

- Synthesizable response checker for the 2-bit xy output of the chapter FSMs (fsm_prob_a family).
- Holds a programmable table of expected xy values, with an optional don't-care per entry.
- After a start, samples x,y once per clock and compares each sample against the table.
- Reports mismatch count, first failing index and pass/fail, so an FSM can be self-checked in hardware.

---
 rtl/xy_chk_pkg.sv | 19 +
 rtl/xy_exp_mem.sv | 25 ++
 rtl/xy_response_checker.sv | 119 +++++++++++
 tb/tb_xy_response_checker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/xy_chk_pkg.sv
// Shared types for the xy response checker: FSM state encoding and the
// expected-value table entry layout.
package xy_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  typedef struct packed {
    logic care;
    logic x;
    logic y;
  } exp_entry_t;

  localparam int unsigned MISMATCH_IDX_NONE = 0;

endpackage

// File: rtl/xy_exp_mem.sv
// Expected-value table: synchronous write, asynchronous read, contents
// deliberately not reset so a table survives a run abort.
module xy_exp_mem
  import xy_chk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  exp_entry_t       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output exp_entry_t       rdata_o
);

  exp_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xy_response_checker.sv
// Compares a stream of {x,y} samples against a programmable expected table
// and reports mismatch count, first failing index and pass/fail.
module xy_response_checker
  import xy_chk_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [2:0]       load_data,
  input  logic [IDX_W:0]   len,
  input  logic             start,
  input  logic             x,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   err_cnt,
  output logic             first_err_valid,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);

  function automatic logic [IDX_W:0] clamp_len(input logic [IDX_W:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  chk_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W:0]   len_q;
  logic             busy_q, done_q, pass_q, fev_q;
  logic [IDX_W:0]   err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] fei_q;
  logic             mem_we, mismatch, last_sample;
  exp_entry_t       rd_entry;

  // Writes only land in IDLE, so a load during a run cannot disturb it.
  assign mem_we = load_en && (state_q == IDLE);

  xy_exp_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (exp_entry_t'(load_data)),
    .raddr_i (idx_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    mismatch    = rd_entry.care && ({x, y} != {rd_entry.x, rd_entry.y});
    err_cnt_d   = err_cnt_q + (IDX_W+1)'(mismatch);
    last_sample = ({1'b0, idx_q} == (len_q - LEN_ONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      fev_q     <= 1'b0;
      fei_q     <= IDX_W'(MISMATCH_IDX_NONE);
      idx_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q     <= '0;
            err_cnt_q <= '0;
            fev_q     <= 1'b0;
            fei_q     <= IDX_W'(MISMATCH_IDX_NONE);
            len_q     <= clamp_len(len);
            if (len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              pass_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          err_cnt_q <= err_cnt_d;
          if (mismatch && !fev_q) begin
            fev_q <= 1'b1;
            fei_q <= idx_q;
          end
          if (last_sample) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

endmodule

// File: tb/tb_xy_response_checker.sv
// Directed bench for xy_response_checker with hand-computed expectations.
module tb_xy_response_checker;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_en = 1'b0;
  logic [IDX_W-1:0] load_addr = '0;
  logic [2:0]       load_data = '0;
  logic [IDX_W:0]   len = '0;
  logic             start = 1'b0;
  logic             x = 1'b0;
  logic             y = 1'b0;
  logic             busy, done, pass, first_err_valid;
  logic [IDX_W:0]   err_cnt;
  logic [IDX_W-1:0] first_err_idx;

  int checks = 0;
  int failures = 0;
  int done_cnt, done_at;
  bit busy_seen;

  xy_response_checker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .len(len), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IDX_W-1:0] a, input logic [2:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // inj: 0 none, 1 start+load pulse at 2nd sample, 2 rst pulse at 2nd sample
  task automatic run_xy(input int n, input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3, input int inj);
    logic [1:0] sv [4];
    sv = '{s0, s1, s2, s3};
    done_cnt = 0; done_at = -1; busy_seen = 1'b0;
    len = (IDX_W+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
    if (busy) busy_seen = 1'b1;
    if (done) begin done_cnt++; done_at = 0; end
    for (int c = 1; c <= 7; c++) begin
      if (c <= n && c <= 4) {x, y} = sv[c-1];
      else {x, y} = 2'b00;
      if (inj == 1 && c == 2) begin
        start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 3'b111;
      end
      if (inj == 2 && c == 2) rst = 1'b1;
      tick();
      start = 1'b0; load_en = 1'b0; rst = 1'b0;
      if (busy) busy_seen = 1'b1;
      if (done) begin done_cnt++; if (done_at < 0) done_at = c; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
    checks++; if (err_cnt !== 5'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (first_err_valid !== 1'b0 || first_err_idx !== 4'd0) begin failures++;
      $display("FAIL reset_first_err got=%b/%0d exp=0/0", first_err_valid, first_err_idx); end
  endtask

  task automatic test_all_match();
    load(4'd0, 3'b100); load(4'd1, 3'b101); load(4'd2, 3'b111); load(4'd3, 3'b110);
    run_xy(4, 2'b00, 2'b01, 2'b11, 2'b10, 0);
    checks++; if (done_at !== 4 || done_cnt !== 1) begin failures++;
      $display("FAIL match_done got=at%0d/cnt%0d exp=at4/cnt1", done_at, done_cnt); end
    checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL match_busy got=%b exp=1", busy_seen); end
    checks++; if (pass !== 1'b1 || err_cnt !== 5'd0) begin failures++;
      $display("FAIL match_result got=pass%b/err%0d exp=pass1/err0", pass, err_cnt); end
    checks++; if (first_err_valid !== 1'b0) begin failures++; $display("FAIL match_fev got=%b exp=0", first_err_valid); end
  endtask

  task automatic test_mismatch();
    run_xy(4, 2'b00, 2'b11, 2'b11, 2'b00, 0);
    checks++; if (err_cnt !== 5'd2) begin failures++; $display("FAIL mism_err_cnt got=%0d exp=2", err_cnt); end
    checks++; if (first_err_valid !== 1'b1 || first_err_idx !== 4'd1) begin failures++;
      $display("FAIL mism_first_err got=%b/%0d exp=1/1", first_err_valid, first_err_idx); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL mism_pass got=%b exp=0", pass); end
    tick(); tick();
    checks++; if (err_cnt !== 5'd2 || first_err_idx !== 4'd1) begin failures++;
      $display("FAIL mism_hold got=%0d/%0d exp=2/1", err_cnt, first_err_idx); end
  endtask

  task automatic test_dont_care();
    load(4'd2, 3'b000);
    run_xy(4, 2'b00, 2'b01, 2'b10, 2'b10, 0);
    checks++; if (pass !== 1'b1 || err_cnt !== 5'd0) begin failures++;
      $display("FAIL dc_pass got=pass%b/err%0d exp=pass1/err0", pass, err_cnt); end
    run_xy(4, 2'b00, 2'b01, 2'b11, 2'b01, 0);
    checks++; if (err_cnt !== 5'd1 || pass !== 1'b0) begin failures++;
      $display("FAIL dc_err got=err%0d/pass%b exp=err1/pass0", err_cnt, pass); end
    checks++; if (first_err_valid !== 1'b1 || first_err_idx !== 4'd3) begin failures++;
      $display("FAIL dc_first_err got=%b/%0d exp=1/3", first_err_valid, first_err_idx); end
  endtask

  task automatic test_len_zero();
    run_xy(0, 2'b11, 2'b11, 2'b11, 2'b11, 0);
    checks++; if (done_at !== 0 || done_cnt !== 1) begin failures++;
      $display("FAIL len0_done got=at%0d/cnt%0d exp=at0/cnt1", done_at, done_cnt); end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL len0_busy got=%b exp=0", busy_seen); end
    checks++; if (pass !== 1'b1 || err_cnt !== 5'd0 || first_err_valid !== 1'b0) begin failures++;
      $display("FAIL len0_result got=pass%b/err%0d/fev%b exp=1/0/0", pass, err_cnt, first_err_valid); end
  endtask

  task automatic test_ignore_in_run();
    load(4'd2, 3'b111);
    run_xy(4, 2'b00, 2'b01, 2'b11, 2'b10, 1);
    checks++; if (done_at !== 4 || done_cnt !== 1) begin failures++;
      $display("FAIL ign_done got=at%0d/cnt%0d exp=at4/cnt1", done_at, done_cnt); end
    checks++; if (pass !== 1'b1 || err_cnt !== 5'd0) begin failures++;
      $display("FAIL ign_result got=pass%b/err%0d exp=pass1/err0", pass, err_cnt); end
    run_xy(1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    checks++; if (pass !== 1'b1 || err_cnt !== 5'd0) begin failures++;
      $display("FAIL ign_entry0 got=pass%b/err%0d exp=pass1/err0", pass, err_cnt); end
  endtask

  task automatic test_start_with_load();
    load_en = 1'b1; load_addr = 4'd0; load_data = 3'b111;
    start = 1'b1; len = 5'd1;
    tick();
    load_en = 1'b0; start = 1'b0;
    {x, y} = 2'b11;
    tick(); tick();
    checks++; if (pass !== 1'b1 || err_cnt !== 5'd0) begin failures++;
      $display("FAIL startload got=pass%b/err%0d exp=pass1/err0", pass, err_cnt); end
    load(4'd0, 3'b100);
  endtask

  task automatic test_reset_mid_run();
    run_xy(4, 2'b11, 2'b01, 2'b11, 2'b10, 2);
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
    checks++; if (busy !== 1'b0 || err_cnt !== 5'd0 || first_err_valid !== 1'b0 || pass !== 1'b0) begin failures++;
      $display("FAIL abort_state got=busy%b/err%0d/fev%b/pass%b exp=0/0/0/0", busy, err_cnt, first_err_valid, pass); end
    run_xy(4, 2'b00, 2'b01, 2'b11, 2'b10, 0);
    checks++; if (done_at !== 4 || pass !== 1'b1 || err_cnt !== 5'd0) begin failures++;
      $display("FAIL abort_rerun got=at%0d/pass%b/err%0d exp=at4/pass1/err0", done_at, pass, err_cnt); end
  endtask

  task automatic test_len_clamp();
    // len=31 clamps to 16; entries 4..15 are untouched so load them as don't-care
    for (int i = 4; i < DEPTH; i++) load(IDX_W'(i), 3'b000);
    len = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      {x, y} = 2'b11;
      tick();
      if (done && done_at < 0) done_at = c;
    end
    checks++; if (done_at !== 16) begin failures++; $display("FAIL clamp_done got=at%0d exp=at16", done_at); end
    checks++; if (err_cnt !== 5'd3 || first_err_idx !== 4'd0) begin failures++;
      $display("FAIL clamp_err got=%0d/%0d exp=3/0", err_cnt, first_err_idx); end
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_mismatch();
    test_dont_care();
    test_len_zero();
    test_ignore_in_run();
    test_start_with_load();
    test_reset_mid_run();
    test_len_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
